// File: rtl/gnrl_bus_sched_pkg.sv
// Shared state encoding and elaboration helpers for the burst-aware bus scheduler.
package gnrl_bus_sched_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GNT  = 1'b1
  } state_e;

  // Ceiling log2 with a floor of 1, so index and counter vectors never collapse to zero width.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/gnrl_rr_pick.sv
// Combinational round-robin picker: the first requester after ptr_i (wrapping) that is not excluded.
module gnrl_rr_pick
  import gnrl_bus_sched_pkg::*;
#(
  parameter int REQ_NUM = 3,
  parameter int ID_W    = clog2(REQ_NUM)
) (
  input  logic [REQ_NUM-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  input  logic [REQ_NUM-1:0] excl_i,
  output logic [REQ_NUM-1:0] win_o,
  output logic [ID_W-1:0]    id_o,
  output logic               valid_o
);

  logic [REQ_NUM-1:0] cand;
  logic [ID_W-1:0]    idx;

  assign cand    = req_i & ~excl_i;
  assign valid_o = |cand;

  // Walk from the farthest offset to the nearest so the nearest candidate is written last and wins.
  always_comb begin
    win_o = '0;
    id_o  = '0;
    idx   = '0;
    for (int k = REQ_NUM; k >= 1; k--) begin
      idx = ID_W'((int'(ptr_i) + k) % REQ_NUM);
      if (cand[idx]) begin
        win_o      = '0;
        win_o[idx] = 1'b1;
        id_o       = idx;
      end
    end
  end

endmodule

// File: rtl/gnrl_bus_sched.sv
// Burst-aware round-robin scheduler for one shared downstream bus port.
// Define GNRL_BUS_SCHED_TIMEOUT_EN to build the stall watchdog that drives o_timeout.
module gnrl_bus_sched
  import gnrl_bus_sched_pkg::*;
#(
  parameter int  REQ_NUM = 3,
  parameter int  BURST_W = 4,
  parameter int  TIMEOUT = 64,
  localparam int ID_W    = clog2(REQ_NUM)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [REQ_NUM-1:0]         i_req_vec,
  input  logic [REQ_NUM*BURST_W-1:0] i_req_len,
  input  logic                       i_beat_acc,
  output logic [REQ_NUM-1:0]         o_gnt_vec,
  output logic [ID_W-1:0]            o_gnt_id,
  output logic                       o_busy,
  output logic                       o_last_beat,
  output logic                       o_timeout
);

  state_e               state_q, state_d;
  logic [REQ_NUM-1:0]   gnt_vec_q, gnt_vec_d;
  logic [ID_W-1:0]      gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]      last_q, last_d;
  logic [BURST_W-1:0]   len_q, len_d;
  logic [BURST_W-1:0]   beat_cnt_q, beat_cnt_d;

  logic                 busy, last_beat, drop, wdog_fire;
  logic                 gnt_en, rel_en;
  logic [REQ_NUM-1:0]   pick_win;
  logic [ID_W-1:0]      pick_id;
  logic                 pick_valid;
  logic [BURST_W-1:0]   len_sel;

  assign busy      = (state_q == ST_GNT);
  assign last_beat = busy & i_beat_acc & (beat_cnt_q == len_q);
  assign drop      = busy & ~|(i_req_vec & gnt_vec_q);
  assign len_sel   = BURST_W'(i_req_len >> (int'(pick_id) * BURST_W));

  // Excluding the current grantee during re-arbitration keeps a busy requester from starving the rest.
  gnrl_rr_pick #(
    .REQ_NUM (REQ_NUM),
    .ID_W    (ID_W)
  ) u_pick (
    .req_i   (i_req_vec),
    .ptr_i   (last_q),
    .excl_i  (busy ? gnt_vec_q : '0),
    .win_o   (pick_win),
    .id_o    (pick_id),
    .valid_o (pick_valid)
  );

`ifdef GNRL_BUS_SCHED_TIMEOUT_EN
  localparam int STALL_W = clog2(TIMEOUT);
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               timeout_q, timeout_d;
  assign wdog_fire = busy & ~i_beat_acc & (stall_q == STALL_W'(TIMEOUT - 1));
`else
  assign wdog_fire = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_d    = state_q;
    gnt_vec_d  = gnt_vec_q;
    gnt_id_d   = gnt_id_q;
    last_d     = last_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    gnt_en     = 1'b0;
    rel_en     = 1'b0;

    if (state_q == ST_IDLE) begin
      gnt_en = pick_valid;
    end else if (last_beat) begin
      gnt_en = pick_valid;
      rel_en = ~pick_valid;
    end else if (drop || wdog_fire) begin
      rel_en = 1'b1;
    end else if (i_beat_acc) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
    end

    if (gnt_en) begin
      state_d    = ST_GNT;
      gnt_vec_d  = pick_win;
      gnt_id_d   = pick_id;
      last_d     = pick_id;
      len_d      = len_sel;
      beat_cnt_d = '0;
    end else if (rel_en) begin
      state_d    = ST_IDLE;
      gnt_vec_d  = '0;
      gnt_id_d   = '0;
      beat_cnt_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gnt_vec_q  <= '0;
      gnt_id_q   <= '0;
      last_q     <= ID_W'(REQ_NUM - 1);
      len_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_vec_q  <= gnt_vec_d;
      gnt_id_q   <= gnt_id_d;
      last_q     <= last_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef GNRL_BUS_SCHED_TIMEOUT_EN
  always_comb begin
    stall_d   = stall_q;
    timeout_d = wdog_fire & ~last_beat & ~drop;
    if (gnt_en || rel_en) begin
      stall_d = '0;
    end else if (busy) begin
      stall_d = i_beat_acc ? '0 : stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  // Watchdog not built; TIMEOUT is still referenced so both builds share one parameter list.
  assign o_timeout = 1'b0 & (TIMEOUT > 0);
`endif

  assign o_gnt_vec   = gnt_vec_q;
  assign o_gnt_id    = gnt_id_q;
  assign o_busy      = busy;
  assign o_last_beat = last_beat;

endmodule

// File: tb/tb_gnrl_bus_sched.sv
// Self-checking bench for gnrl_bus_sched: directed scenarios, then random traffic against a burst-level model.
module tb_gnrl_bus_sched;

  localparam int N  = 3;
  localparam int BW = 4;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*BW-1:0] lens;
  logic            acc;
  logic [N-1:0]    o_gnt_vec;
  logic [1:0]      o_gnt_id;
  logic            o_busy, o_last_beat, o_timeout;

  int checks = 0;
  int errors = 0;

  // Burst-level reference: owner, beats remaining, round-robin pointer, stall cycles.
  bit m_busy, m_to, m_done;
  int m_owner, m_left, m_last, m_stall, m_done_id;

  always #5 clk = ~clk;

  gnrl_bus_sched #(
    .REQ_NUM (N),
    .BURST_W (BW),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req_vec   (req),
    .i_req_len   (lens),
    .i_beat_acc  (acc),
    .o_gnt_vec   (o_gnt_vec),
    .o_gnt_id    (o_gnt_id),
    .o_busy      (o_busy),
    .o_last_beat (o_last_beat),
    .o_timeout   (o_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_left = 0; m_last = N - 1;
    m_stall = 0; m_to = 0; m_done = 0; m_done_id = 0;
  endtask

  function automatic int pick(input logic [N-1:0] r, input int excl);
    for (int k = 1; k <= N; k++) begin
      if (r[(m_last + k) % N] && ((m_last + k) % N) != excl) return (m_last + k) % N;
    end
    return -1;
  endfunction

  task automatic grant_to(input int w);
    m_busy  = 1;
    m_owner = w;
    m_left  = int'(BW'(lens >> (w * BW))) + 1;
    m_last  = w;
    m_stall = 0;
  endtask

  // Check outputs mid-cycle against the model, then advance the model across the next rising edge.
  task automatic cycle(input int exp_vec = -1, input int exp_lb = -1, input int exp_to = -1);
    int  w;
    bit  lb;
    @(negedge clk);
    lb = m_busy && acc && (m_left == 1);
    chk("gnt_vec",   o_gnt_vec,   m_busy ? (1 << m_owner) : 0);
    chk("gnt_id",    o_gnt_id,    m_busy ? m_owner : 0);
    chk("busy",      o_busy,      m_busy);
    chk("last_beat", o_last_beat, lb);
    chk("timeout",   o_timeout,   m_to);
    if (exp_vec >= 0) chk("dir_gnt_vec",   o_gnt_vec,   exp_vec);
    if (exp_lb  >= 0) chk("dir_last_beat", o_last_beat, exp_lb);
    if (exp_to  >= 0) chk("dir_timeout",   o_timeout,   exp_to);
    m_done = 0;
    m_to   = 0;
    if (rst) begin
      model_reset();
    end else if (!m_busy) begin
      w = pick(req, -1);
      if (w >= 0) grant_to(w);
    end else if (lb) begin
      m_done = 1; m_done_id = m_owner;
      w = pick(req, m_owner);
      if (w >= 0) grant_to(w); else m_busy = 0;
    end else if (!req[m_owner]) begin
      m_busy = 0;
`ifdef GNRL_BUS_SCHED_TIMEOUT_EN
    end else if (!acc && m_stall == TO - 1) begin
      m_busy = 0; m_to = 1;
`endif
    end else if (acc) begin
      m_left--; m_stall = 0;
    end else begin
      m_stall++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_out();
    req = '0; acc = 1'b1;
    repeat (3) cycle();
  endtask

  initial begin
    rst = 1'b1; req = '0; lens = '0; acc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    cycle(0, 0, 0);
    rst = 1'b0;

    // Single burst of 4 beats; request drops during the last beat, which still completes.
    req = 3'b001; lens = 12'h003; acc = 1'b1;
    cycle(0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) req = '0;
      cycle(1, (i == 3) ? 1 : 0);
    end
    cycle(0, 0);

    // Everyone requesting single-beat bursts after a fresh reset: 0,1,2,0 with no bubble.
    rst = 1'b1; cycle(); rst = 1'b0;
    req = 3'b111; lens = '0; acc = 1'b1;
    cycle(0);
    cycle(1, 1); cycle(2, 1); cycle(4, 1); cycle(1, 1);
    idle_out();

    // Two-beat burst with stalls in between beats.
    req = 3'b010; lens = 12'h010; acc = 1'b0;
    cycle(0);
    acc = 1'b1; cycle(2, 0);
    acc = 1'b0; cycle(2, 0); cycle(2, 0);
    acc = 1'b1; req = '0; cycle(2, 1);
    cycle(0, 0);

    // Early drop after two beats of an 8-beat burst; requester 0 picks up afterwards.
    req = 3'b100; lens = 12'h700; acc = 1'b1;
    cycle(0);
    cycle(4, 0); cycle(4, 0);
    req = 3'b001; acc = 1'b0;
    cycle(4, 0); cycle(0, 0); cycle(1, 0);
    idle_out();

    // Stalled burst: watchdog release, or indefinite hold when not built.
    req = 3'b001; lens = 12'h003; acc = 1'b0;
    cycle(0);
`ifdef GNRL_BUS_SCHED_TIMEOUT_EN
    for (int i = 0; i < 8; i++) cycle(1, 0, 0);
    cycle(0, 0, 1);
`else
    for (int i = 0; i < 20; i++) cycle(1, 0, 0);
`endif
    idle_out();

    // Reset during beat 2 of 5: outputs clear and requester 0 regains priority.
    req = 3'b001; lens = 12'h004; acc = 1'b1;
    cycle(0);
    cycle(1, 0);
    rst = 1'b1; cycle(1, 0);
    rst = 1'b0; req = 3'b011;
    cycle(0, 0, 0);
    cycle(1);
    idle_out();

    // Random traffic: sticky requests, occasional aborts, random lengths, beats and resets.
    for (int c = 0; c < 600; c++) begin
      logic [N-1:0] r;
      r = req;
      for (int k = 0; k < N; k++) begin
        if (m_done && m_done_id == k && $urandom_range(0, 9) < 7) r[k] = 1'b0;
        else if (m_busy && m_owner == k && $urandom_range(0, 49) == 0) r[k] = 1'b0;
        else if (!r[k] && $urandom_range(0, 9) < 3) r[k] = 1'b1;
        lens[k*BW +: BW] = ($urandom_range(0, 7) == 0) ? BW'($urandom_range(0, 15))
                                                         : BW'($urandom_range(0, 3));
      end
      req = r;
      acc = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0;
    idle_out();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
